// File: rtl/rv_pipe_pkg.sv
// Shared types and helpers for the rv32 pipeline hazard/forwarding logic.
package rv_pipe_pkg;

  // Scoreboard destination field; wide enough for any supported REG_AW.
  localparam int unsigned SB_RD_W  = 8;
  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               we;
    logic               is_load;
  } sb_entry_t;

  // Width of a forward-select code: 0 = register file, 1..num_stages = stage.
  function automatic int unsigned fwd_sel_w(input int unsigned num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/rv_hazard_scoreboard_if.sv
// ID-stage request, forwarding sources and hazard/forward results.
interface rv_hazard_scoreboard_if
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned SEL_W = fwd_sel_w(NUM_STAGES);

  logic                         id_valid;
  logic [REG_AW-1:0]            id_rs1;
  logic [REG_AW-1:0]            id_rs2;
  logic                         id_uses_rs2;
  logic [REG_AW-1:0]            id_rd;
  logic                         id_we;
  logic                         id_is_load;
  logic [XLEN-1:0]              rf_data1;
  logic [XLEN-1:0]              rf_data2;
  logic [NUM_STAGES*XLEN-1:0]   stage_data;
  logic                         flush;
  logic                         stall;
  logic [XLEN-1:0]              op1;
  logic [XLEN-1:0]              op2;
  logic [SEL_W-1:0]             fwd_sel1;
  logic [SEL_W-1:0]             fwd_sel2;
  logic [CNT_W-1:0]             stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_we, id_is_load,
    output rf_data1, rf_data2, stage_data, flush,
    input  stall, op1, op2, fwd_sel1, fwd_sel2, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_we, id_is_load,
    input  rf_data1, rf_data2, stage_data, flush,
    output stall, op1, op2, fwd_sel1, fwd_sel2, stall_cycles
  );

endinterface

// File: rtl/rv_operand_fwd.sv
// One source operand: youngest-match search, load readiness and operand mux.
module rv_operand_fwd
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned LOAD_LAT   = 2
) (
  input  sb_entry_t [NUM_STAGES-1:0]      ent,
  input  logic [REG_AW-1:0]               rs,
  input  logic                            en,
  input  logic [NUM_STAGES*XLEN-1:0]      stage_data,
  input  logic [XLEN-1:0]                 rf_data,
  output logic [XLEN-1:0]                 op,
  output logic [fwd_sel_w(NUM_STAGES)-1:0] sel,
  output logic                            not_ready
);
  localparam int unsigned SEL_W = fwd_sel_w(NUM_STAGES);

  logic            hit;
  logic            hit_load;
  int              hit_k;
  logic [XLEN-1:0] hit_data;
  logic            ready;

  // Scan oldest to youngest so the lowest-index (youngest) match overrides.
  always_comb begin
    hit      = 1'b0;
    hit_load = 1'b0;
    hit_k    = 0;
    hit_data = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (en && rs != REG_AW'(REG_ZERO) && ent[i].valid && ent[i].we &&
          ent[i].rd == SB_RD_W'(rs)) begin
        hit      = 1'b1;
        hit_load = ent[i].is_load;
        hit_k    = i + 1;
        hit_data = stage_data[i*XLEN +: XLEN];
      end
    end
  end

  // Load data only exists from stage LOAD_LAT onward.
  always_comb begin
    ready     = !(hit_load && hit_k < int'(LOAD_LAT));
    op        = rf_data;
    sel       = '0;
    not_ready = 1'b0;
    if (hit && ready) begin
      op  = hit_data;
      sel = SEL_W'(hit_k);
    end else if (hit) begin
      not_ready = 1'b1;
    end
  end

endmodule

// File: rtl/rv_hazard_scoreboard.sv
// ID/EX hazard scoreboard: tracks in-flight writers, forwards operands, stalls.
module rv_hazard_scoreboard
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned LOAD_LAT   = 2,
  parameter int unsigned CNT_W      = 16
) (
  input logic                   clk,
  input logic                   reset,
  rv_hazard_scoreboard_if.slave bus
);
  sb_entry_t [NUM_STAGES-1:0] sb;
  sb_entry_t                  id_entry;
  logic                       en1;
  logic                       en2;
  logic                       nr1;
  logic                       nr2;
  logic                       stall_c;
  logic                       insert;
  logic [CNT_W-1:0]           cnt;

  // Entry describing the instruction currently in ID.
  always_comb begin
    id_entry         = '0;
    id_entry.valid   = 1'b1;
    id_entry.rd      = SB_RD_W'(bus.id_rd);
    id_entry.we      = bus.id_we;
    id_entry.is_load = bus.id_is_load;
  end

  // Operand lookup is disabled in reset so the RF values pass straight through.
  assign en1 = !reset;
  assign en2 = !reset && bus.id_uses_rs2;

  // Flush wins over stall; stalled or flushed instructions become bubbles.
  assign stall_c = bus.id_valid && !bus.flush && !reset && (nr1 || nr2);
  assign insert  = bus.id_valid && !stall_c && !bus.flush;

  // Scoreboard shift register, stage 1 at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb <= '0;
    end else begin
      sb[0] <= insert ? id_entry : sb_entry_t'('0);
      for (int k = 1; k < int'(NUM_STAGES); k++) begin
        sb[k] <= sb[k-1];
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (stall_c && cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.stall        = stall_c;
  assign bus.stall_cycles = cnt;

  rv_operand_fwd #(
    .XLEN(XLEN), .REG_AW(REG_AW), .NUM_STAGES(NUM_STAGES), .LOAD_LAT(LOAD_LAT)
  ) u_fwd1 (
    .ent(sb), .rs(bus.id_rs1), .en(en1), .stage_data(bus.stage_data),
    .rf_data(bus.rf_data1), .op(bus.op1), .sel(bus.fwd_sel1), .not_ready(nr1)
  );

  rv_operand_fwd #(
    .XLEN(XLEN), .REG_AW(REG_AW), .NUM_STAGES(NUM_STAGES), .LOAD_LAT(LOAD_LAT)
  ) u_fwd2 (
    .ent(sb), .rs(bus.id_rs2), .en(en2), .stage_data(bus.stage_data),
    .rf_data(bus.rf_data2), .op(bus.op2), .sel(bus.fwd_sel2), .not_ready(nr2)
  );

endmodule

// File: tb/tb_rv_hazard_scoreboard.sv
// Directed bench: default config (3 stages, load latency 2) and a deep config (4/3).
module tb_rv_hazard_scoreboard;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   total;
  int   bad;

  rv_hazard_scoreboard_if #(.XLEN(32), .REG_AW(5), .NUM_STAGES(3), .CNT_W(16)) ia ();
  rv_hazard_scoreboard_if #(.XLEN(32), .REG_AW(5), .NUM_STAGES(4), .CNT_W(16)) ib ();

  rv_hazard_scoreboard #(
    .XLEN(32), .REG_AW(5), .NUM_STAGES(3), .LOAD_LAT(2), .CNT_W(16)
  ) u_a (.clk(clk), .reset(rst_a), .bus(ia.slave));

  rv_hazard_scoreboard #(
    .XLEN(32), .REG_AW(5), .NUM_STAGES(4), .LOAD_LAT(3), .CNT_W(16)
  ) u_b (.clk(clk), .reset(rst_b), .bus(ib.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic id_a(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    ia.id_valid = v;  ia.id_rs1 = rs1; ia.id_rs2 = rs2; ia.id_uses_rs2 = u2;
    ia.id_rd = rd;    ia.id_we = we;   ia.id_is_load = ld;
  endtask

  task automatic id_b(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    ib.id_valid = v;  ib.id_rs1 = rs1; ib.id_rs2 = rs2; ib.id_uses_rs2 = u2;
    ib.id_rd = rd;    ib.id_we = we;   ib.id_is_load = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    clk = 1'b0; total = 0; bad = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    ia.flush = 1'b0; ia.stage_data = '0; ia.rf_data1 = 32'h1234; ia.rf_data2 = 32'h5678;
    ib.flush = 1'b0; ib.stage_data = '0; ib.rf_data1 = 32'h77;   ib.rf_data2 = 32'h0;
    id_a(1, 7, 7, 1, 7, 1, 1);
    id_b(0, 0, 0, 0, 0, 0, 0);

    // Reset values
    tick(); tick(); settle();
    chk("a_rst_stall", 64'(ia.stall), 64'd0);
    chk("a_rst_sel1", 64'(ia.fwd_sel1), 64'd0);
    chk("a_rst_sel2", 64'(ia.fwd_sel2), 64'd0);
    chk("a_rst_op1", 64'(ia.op1), 64'h1234);
    chk("a_rst_op2", 64'(ia.op2), 64'h5678);
    chk("a_rst_cnt", 64'(ia.stall_cycles), 64'd0);

    // ADD x5 enters an empty scoreboard
    rst_a = 1'b0;
    id_a(1, 1, 2, 1, 5, 1, 0); settle();
    chk("a_add5_stall", 64'(ia.stall), 64'd0);
    chk("a_add5_sel1", 64'(ia.fwd_sel1), 64'd0);
    tick();

    // ADD x6,x5,x5 forwards from stage 1
    id_a(1, 5, 5, 1, 6, 1, 0); ia.stage_data = {32'h0, 32'h0, 32'h11}; settle();
    chk("a_ex_stall", 64'(ia.stall), 64'd0);
    chk("a_ex_op1", 64'(ia.op1), 64'h11);
    chk("a_ex_op2", 64'(ia.op2), 64'h11);
    chk("a_ex_sel1", 64'(ia.fwd_sel1), 64'd1);
    chk("a_ex_sel2", 64'(ia.fwd_sel2), 64'd1);
    tick();

    // LW x7; rs2 field hits x6 but is not used
    id_a(1, 1, 6, 0, 7, 1, 1); settle();
    chk("a_lw_stall", 64'(ia.stall), 64'd0);
    chk("a_nouse_sel2", 64'(ia.fwd_sel2), 64'd0);
    chk("a_nouse_op2", 64'(ia.op2), 64'h5678);
    tick();

    // SW x7,0(x7): load-use stall
    id_a(1, 7, 7, 1, 0, 0, 0); settle();
    chk("a_lu_stall", 64'(ia.stall), 64'd1);
    chk("a_lu_cnt0", 64'(ia.stall_cycles), 64'd0);
    tick();

    // Load now in stage 2
    ia.stage_data = {32'h0, 32'hDEADBEEF, 32'h0}; settle();
    chk("a_lu2_stall", 64'(ia.stall), 64'd0);
    chk("a_lu2_cnt", 64'(ia.stall_cycles), 64'd1);
    chk("a_lu2_op1", 64'(ia.op1), 64'hDEADBEEF);
    chk("a_lu2_op2", 64'(ia.op2), 64'hDEADBEEF);
    chk("a_lu2_sel1", 64'(ia.fwd_sel1), 64'd2);
    chk("a_lu2_sel2", 64'(ia.fwd_sel2), 64'd2);
    tick();

    // ADD x3,x7,x0: load reaches stage 3; x0 source uses RF
    id_a(1, 7, 0, 1, 3, 1, 0); ia.stage_data = {32'h333, 32'h0, 32'h0}; settle();
    chk("a_s3_op1", 64'(ia.op1), 64'h333);
    chk("a_s3_sel1", 64'(ia.fwd_sel1), 64'd3);
    chk("a_s3_sel2", 64'(ia.fwd_sel2), 64'd0);
    chk("a_s3_op2", 64'(ia.op2), 64'h5678);
    tick();
    id_a(1, 0, 0, 0, 9, 1, 0); tick();
    id_a(1, 0, 0, 0, 3, 1, 0); tick();

    // x3 in stages 1 and 3: youngest wins; this instruction writes x0
    id_a(1, 3, 3, 1, 0, 1, 0); ia.stage_data = {32'hBB, 32'h99, 32'hAA}; settle();
    chk("a_young_op1", 64'(ia.op1), 64'hAA);
    chk("a_young_sel1", 64'(ia.fwd_sel1), 64'd1);
    chk("a_young_op2", 64'(ia.op2), 64'hAA);
    tick();

    // Reader of x0 ignores the x0 writer in stage 1
    id_a(1, 0, 0, 1, 8, 1, 1); ia.rf_data1 = 32'h0; ia.stage_data = {32'h0, 32'h0, 32'h55};
    settle();
    chk("a_x0_op1", 64'(ia.op1), 64'h0);
    chk("a_x0_sel1", 64'(ia.fwd_sel1), 64'd0);
    chk("a_x0_stall", 64'(ia.stall), 64'd0);
    tick();

    // Load-use on x8 with flush: no stall, writer of x10 is killed
    id_a(1, 8, 0, 0, 10, 1, 0); ia.flush = 1'b1; settle();
    chk("a_flush_stall", 64'(ia.stall), 64'd0);
    tick();
    ia.flush = 1'b0;
    id_a(1, 10, 8, 1, 0, 0, 0); ia.rf_data1 = 32'h1010; ia.stage_data = {32'h0, 32'h88, 32'h0};
    settle();
    chk("a_flushed_sel1", 64'(ia.fwd_sel1), 64'd0);
    chk("a_flushed_op1", 64'(ia.op1), 64'h1010);
    chk("a_flush_sel2", 64'(ia.fwd_sel2), 64'd2);
    chk("a_flush_op2", 64'(ia.op2), 64'h88);
    chk("a_flush_cnt", 64'(ia.stall_cycles), 64'd1);
    tick();

    // LW x11, then an invalid ID slot that would otherwise hazard
    id_a(1, 0, 0, 0, 11, 1, 1); tick();
    id_a(0, 11, 0, 0, 0, 0, 0); settle();
    chk("a_novalid_stall", 64'(ia.stall), 64'd0);
    tick();
    id_a(1, 11, 0, 0, 0, 0, 0); ia.stage_data = {32'h0, 32'h1111, 32'h0}; settle();
    chk("a_bub_stall", 64'(ia.stall), 64'd0);
    chk("a_bub_sel1", 64'(ia.fwd_sel1), 64'd2);
    chk("a_bub_op1", 64'(ia.op1), 64'h1111);
    id_a(0, 0, 0, 0, 0, 0, 0);

    // Deep config: LW x4 then dependent stalls two cycles
    rst_b = 1'b0;
    id_b(1, 0, 0, 0, 4, 1, 1); settle();
    chk("b_lw_stall", 64'(ib.stall), 64'd0);
    tick();
    id_b(1, 4, 0, 0, 12, 1, 0); settle();
    chk("b_st1_stall", 64'(ib.stall), 64'd1);
    chk("b_st1_cnt", 64'(ib.stall_cycles), 64'd0);
    tick(); settle();
    chk("b_st2_stall", 64'(ib.stall), 64'd1);
    chk("b_st2_cnt", 64'(ib.stall_cycles), 64'd1);
    tick();
    ib.stage_data = {32'h0, 32'hC0FFEE, 32'h0, 32'h0}; settle();
    chk("b_fw3_stall", 64'(ib.stall), 64'd0);
    chk("b_fw3_sel1", 64'(ib.fwd_sel1), 64'd3);
    chk("b_fw3_op1", 64'(ib.op1), 64'hC0FFEE);
    chk("b_fw3_cnt", 64'(ib.stall_cycles), 64'd2);
    tick();

    // Load in last stage must still forward
    id_b(1, 4, 0, 0, 0, 0, 0); ib.stage_data = {32'h44, 32'h0, 32'h0, 32'h0}; settle();
    chk("b_fw4_sel1", 64'(ib.fwd_sel1), 64'd4);
    chk("b_fw4_op1", 64'(ib.op1), 64'h44);
    tick();

    // Second load-use; reset during the second stall cycle
    id_b(1, 0, 0, 0, 4, 1, 1); tick();
    id_b(1, 4, 0, 0, 12, 1, 0); settle();
    chk("b_r_st1", 64'(ib.stall), 64'd1);
    tick(); settle();
    chk("b_r_st2", 64'(ib.stall), 64'd1);
    chk("b_r_cnt3", 64'(ib.stall_cycles), 64'd3);
    rst_b = 1'b1; settle();
    chk("b_r_stall0", 64'(ib.stall), 64'd0);
    chk("b_r_sel1", 64'(ib.fwd_sel1), 64'd0);
    chk("b_r_op1", 64'(ib.op1), 64'h77);
    tick(); settle();
    chk("b_r_cnt0", 64'(ib.stall_cycles), 64'd0);
    rst_b = 1'b0; settle();
    chk("b_clr_stall", 64'(ib.stall), 64'd0);
    chk("b_clr_sel1", 64'(ib.fwd_sel1), 64'd0);
    chk("b_clr_op1", 64'(ib.op1), 64'h77);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_hazard_scoreboard.md
Name: rv_hazard_scoreboard

Overview:
Parametrised hazard-detection and operand-forwarding unit for the pipelined rv32 core. It sits at the ID/EX boundary and keeps a shift-register scoreboard of in-flight instructions (EX/MEM through WB). Each cycle it selects forwarded or register-file operands for the instruction leaving ID and raises a stall when a producer's data is not yet available. It generalises the fixed EX/MEM/WB forwarding and single-cycle load-use stall to configurable pipeline depth and load latency, and adds flush handling and a stall performance counter.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width
NUM_STAGES, 3, tracked stages after ID (1=EX/MEM, 2=MEM/WB, 3=WB); must be >=1
LOAD_LAT, 2, first stage index at which load data is valid; 1<=LOAD_LAT<=NUM_STAGES
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  source 1
id_rs2  in  REG_AW  source 2
id_uses_rs2  in  1  rs2 is read (R-type, store, branch)
id_rd  in  REG_AW  destination
id_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
rf_data1  in  XLEN  register-file read of rs1
rf_data2  in  XLEN  register-file read of rs2
stage_data  in  NUM_STAGES*XLEN  result held in stage k at slice [(k-1)*XLEN +: XLEN]
flush  in  1  branch/jump redirect resolved this cycle; kill ID instruction
stall  out  1  hold PC and IF/ID, insert bubble into EX
op1  out  XLEN  resolved rs1 value
op2  out  XLEN  resolved rs2 value
fwd_sel1  out  $clog2(NUM_STAGES+1)  0=RF, k=stage k
fwd_sel2  out  $clog2(NUM_STAGES+1)  same for rs2
stall_cycles  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Scoreboard entries e[1..NUM_STAGES], each {valid, rd, we, is_load}. Reset clears all valid bits.
- Every clock edge (no reset): e[k+1]<=e[k]. e[1]<=ID instruction if id_valid && !stall && !flush, else bubble (valid=0). e[NUM_STAGES] is discarded.
- Match for operand rs: e[k].valid && e[k].we && e[k].rd==rs && rs!=0. The youngest match (lowest k) wins. Older matches are ignored.
- Ready: a match is ready unless e[k].is_load && k<LOAD_LAT.
- Operand resolution (combinational): youngest ready match k gives op=stage_data slice k and fwd_sel=k. No match gives op=rf_data and fwd_sel=0. rs2 is resolved only when id_uses_rs2; otherwise op2=rf_data2 and fwd_sel2=0.
- stall = id_valid && !flush && !reset && (youngest rs1 match not ready || (id_uses_rs2 && youngest rs2 match not ready)).
- A load in e[1] followed by a dependent instruction stalls LOAD_LAT-1 cycles, then forwards from stage LOAD_LAT.
- Flush overrides stall: stall=0 and the ID instruction is not inserted.
- The last stage covers the RF write cycle, so forwarding from stage NUM_STAGES is mandatory. The RF may not be write-through.
- stall_cycles increments on every cycle with stall=1 and saturates at all-ones.
- Reset values, while reset is high: stall=0, fwd_sel1=fwd_sel2=0, op1=rf_data1, op2=rf_data2, stall_cycles=0. All entries are invalid from the next edge.
- Reset asserted mid-stall: stall drops in the same cycle and the scoreboard clears at the edge.
- id_valid=0: no stall; a bubble is inserted.

Decomposition:
- Package rv_pipe_pkg holds:
  - sb_entry_t struct {valid, rd, we, is_load};
  - localparam function for the fwd_sel width;
  - REG_ZERO constant.
- Sub-module rv_operand_fwd: one operand's priority match, ready check, mux and not-ready flag across all entries. It is instantiated twice (rs1, rs2).

Test Plan:
- ADD x5 into e[1]; next instruction ADD x6,x5,x5, stage1 data 0x11 -> stall=0, op1=op2=0x11, fwd_sel1=fwd_sel2=1.
- LW x7 (LOAD_LAT=2), then SW x7,0(x7) -> stall=1 for exactly 1 cycle, stall_cycles=1. Next cycle the load is in stage 2 with data 0xDEADBEEF -> op1=op2=0xDEADBEEF, fwd_sel=2.
- x3 written in stages 1 and 3 (0xAA, 0xBB); reader of x3 -> op1=0xAA, fwd_sel1=1 (youngest wins).
- Writer to x0 in stage 1 with data 0x55; reader of x0 with rf_data1=0 -> op1=0, fwd_sel1=0, stall=0.
- Load-use hazard with flush=1 in the same cycle -> stall=0; next cycle e[1].valid=0.
- LOAD_LAT=3, NUM_STAGES=4: load followed by dependent -> 2 stall cycles, then forward from stage 3. Reset asserted during the second stall cycle -> stall=0 immediately and stall_cycles=0 after the edge.
